// File: rtl/xn_stream_src.sv
// xn_stream_src: streams len samples from a 1-cycle-latency BRAM out as an AXI-Stream master.
// Optional XN_SRC_FLUSH_EN appends pFLUSH zero beats (no BRAM reads) after the BRAM samples.
module xn_stream_src #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pLEN_WIDTH  = 16,
  parameter int unsigned pFLUSH      = 10
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   start,
  input  logic [pLEN_WIDTH-1:0]  len,
  input  logic [pADDR_WIDTH-1:0] base_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   src_EN,
  output logic [pADDR_WIDTH-1:0] src_A,
  input  logic [pDATA_WIDTH-1:0] src_Do,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready
);

`ifdef XN_SRC_FLUSH_EN
  localparam int unsigned CntW       = pLEN_WIDTH + 1;
  localparam int unsigned FlushBeats = pFLUSH;
`else
  localparam int unsigned CntW       = pLEN_WIDTH;
  // Without the flush feature no zero beats are appended.
  localparam int unsigned FlushBeats = pFLUSH * 0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q;
  logic [pLEN_WIDTH-1:0]  len_q;
  logic [CntW-1:0]        total_q;
  logic [CntW-1:0]        rd_cnt_q;
  logic [pADDR_WIDTH-1:0] base_q;
  logic                   infl_q;
  logic                   infl_last_q;
  logic                   infl_zero_q;
  logic [1:0]             occ_q;
  logic [pDATA_WIDTH-1:0] data0_q, data1_q;
  logic                   last0_q, last1_q;

  logic                   pop;
  logic                   room;
  logic                   is_bram;
  logic                   issue;
  logic [CntW-1:0]        start_total;
  logic [pDATA_WIDTH-1:0] push_data;

  always_comb begin
    m_tvalid    = (occ_q != 2'd0);
    m_tdata     = data0_q;
    m_tlast     = last0_q;
    busy        = (state_q == StRun);
    done        = (state_q == StDone);
    pop         = m_tvalid & m_tready;
    // occupancy + inflight - pop < 2, rearranged to avoid underflow
    room        = ({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
    is_bram     = rd_cnt_q < CntW'(len_q);
    issue       = (state_q == StRun) && (rd_cnt_q < total_q) && room;
    src_EN      = issue & is_bram;
    src_A       = base_q + pADDR_WIDTH'({rd_cnt_q, 2'b00});
    start_total = CntW'(len) + CntW'(FlushBeats);
    push_data   = infl_zero_q ? '0 : src_Do;
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      total_q     <= '0;
      rd_cnt_q    <= '0;
      base_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_zero_q <= 1'b0;
      occ_q       <= 2'd0;
      data0_q     <= '0;
      data1_q     <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q    <= len;
            total_q  <= start_total;
            rd_cnt_q <= '0;
            base_q   <= {base_addr[pADDR_WIDTH-1:2], 2'b00};
            state_q  <= (start_total == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (pop && m_tlast) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      infl_q <= issue;
      if (issue) begin
        rd_cnt_q    <= rd_cnt_q + CntW'(1);
        infl_last_q <= (rd_cnt_q + CntW'(1)) == total_q;
        infl_zero_q <= !is_bram;
      end

      // Head is always entry 0; a pop shifts entry 1 forward.
      if (pop) begin
        data0_q <= data1_q;
        last0_q <= last1_q;
      end
      if (infl_q) begin
        if (occ_q == 2'd0 || (occ_q == 2'd1 && pop)) begin
          data0_q <= push_data;
          last0_q <= infl_last_q;
        end else begin
          data1_q <= push_data;
          last1_q <= infl_last_q;
        end
      end
      occ_q <= occ_q + {1'b0, infl_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_xn_stream_src.sv
// Directed self-checking bench for xn_stream_src with a behavioural 1-cycle-latency BRAM.
module tb_xn_stream_src;

`ifdef XN_SRC_FLUSH_EN
  localparam int FL = 10;
`else
  localparam int FL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [11:0] base_addr = '0;
  logic        busy, done, src_en, m_tvalid, m_tlast;
  logic [11:0] src_a;
  logic [31:0] src_do = '0;
  logic [31:0] m_tdata;
  logic        m_tready = 1'b0;

  logic [31:0] mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  int          beats[$];
  int          lasts[$];
  int          exp_q[$];
  logic [11:0] addrs[$];
  int          done_cyc, first_v, stall_bad, max_out, busy_cycles;

  always #5 clk = ~clk;

  always @(posedge clk) if (src_en) src_do <= mem[src_a[11:2]];

  xn_stream_src #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .pLEN_WIDTH (16),
    .pFLUSH     (10)
  ) dut (
    .axis_clk (clk),
    .axis_rst (rst),
    .start    (start),
    .len      (len),
    .base_addr(base_addr),
    .busy     (busy),
    .done     (done),
    .src_EN   (src_en),
    .src_A    (src_a),
    .src_Do   (src_do),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .m_tready (m_tready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) return (c % 4 == 0) || (c % 4 == 3);
    return 1'b1;
  endfunction

  // Start in cycle 0, then run cycle by cycle: drive inputs at the falling edge, sample 1ns later.
  task automatic run_xfer(input string tag, input int n, input logic [11:0] base, input int mode,
                          input int restart_at, input int stop_beats);
    int iss, pops;
    logic pstall, plast;
    logic [31:0] pdata;
    beats.delete(); lasts.delete(); addrs.delete();
    done_cyc = -1; first_v = -1; stall_bad = 0; max_out = 0; busy_cycles = 0;
    iss = 0; pops = 0; pstall = 1'b0; plast = 1'b0; pdata = '0;
    @(negedge clk);
    start = 1'b1; len = 16'(n); base_addr = base; m_tready = ready_for(mode, 0);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == restart_at) len = 16'd3;
      m_tready = ready_for(mode, c);
      #1;
      if (pstall && !(m_tvalid && m_tdata == pdata && m_tlast == plast)) stall_bad++;
      if (m_tvalid && first_v < 0) first_v = c;
      if (busy) busy_cycles++;
      if (src_en) begin
        iss++;
        addrs.push_back(src_a);
      end
      if (m_tvalid && m_tready) begin
        pops++;
        beats.push_back(int'(m_tdata));
        if (m_tlast) lasts.push_back(beats.size() - 1);
      end
      if (iss - pops > max_out) max_out = iss - pops;
      pstall = m_tvalid && !m_tready;
      pdata = m_tdata;
      plast = m_tlast;
      if (done) begin
        done_cyc = c;
        break;
      end
      if (stop_beats > 0 && beats.size() >= stop_beats) break;
    end
    start = 1'b0;
    if (stop_beats == 0) check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    int total;
    total = exp_q.size() + FL;
    check({tag, "_nbeats"}, 32'(beats.size()), 32'(total));
    for (int i = 0; i < total && i < beats.size(); i++)
      check($sformatf("%s_d%0d", tag, i), 32'(beats[i]), (i < exp_q.size()) ? 32'(exp_q[i]) : 32'd0);
    check({tag, "_nlast"}, 32'(lasts.size()), 32'd1);
    if (lasts.size() > 0) check({tag, "_last_idx"}, 32'(lasts[0]), 32'(total - 1));
  endtask

  task automatic fill_seq(input int n);
    exp_q.delete();
    for (int i = 1; i <= n; i++) exp_q.push_back(i);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_src_en"}, 32'(src_en), 32'd0);
    check({tag, "_src_a"}, 32'(src_a), 32'd0);
    check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check({tag, "_tdata"}, m_tdata, 32'd0);
    check({tag, "_tlast"}, 32'(m_tlast), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);
    mem[1022] = 32'hAA;
    mem[1023] = 32'hBB;
    mem[100] = 32'd7;
    mem[101] = 32'd8;
    mem[102] = 32'd9;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset");

    // Basic streaming: beats in cycles 3..len+2, done in len+3
    run_xfer("basic", 5, 12'h000, 0, 0, 0);
    fill_seq(5);
    check_stream("basic");
    check("basic_first_valid", 32'(first_v), 32'd3);
    check("basic_done_cyc", 32'(done_cyc), 32'(5 + FL + 3));
    check("basic_busy_cycles", 32'(busy_cycles), 32'(5 + FL + 2));

    // Backpressure: ready pattern 1,0,0,1
    run_xfer("bp", 5, 12'h000, 1, 0, 0);
    fill_seq(5);
    check_stream("bp");
    check("bp_stall_stable", 32'(stall_bad), 32'd0);
    check("bp_max_outstanding", 32'(max_out), 32'd2);

    // Zero length skips RUN: done is the cycle after start
    run_xfer("zero", 0, 12'h000, 0, 0, 0);
    check("zero_nbeats", 32'(beats.size()), 32'(FL));
    check("zero_done_cyc", 32'(done_cyc), (FL == 0) ? 32'd1 : 32'(FL + 3));

    // Second start (len=3) during a len=8 run is ignored
    run_xfer("restart", 8, 12'h000, 0, 4, 0);
    fill_seq(8);
    check_stream("restart");
    check("restart_done_cyc", 32'(done_cyc), 32'(8 + FL + 3));

    // Address wrap
    run_xfer("wrap", 4, 12'hFF8, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(32'hAA); exp_q.push_back(32'hBB); exp_q.push_back(1); exp_q.push_back(2);
    check_stream("wrap");
    check("wrap_nreads", 32'(addrs.size()), 32'd4);
    if (addrs.size() == 4) begin
      check("wrap_a0", 32'(addrs[0]), 32'hFF8);
      check("wrap_a1", 32'(addrs[1]), 32'hFFC);
      check("wrap_a2", 32'(addrs[2]), 32'h000);
      check("wrap_a3", 32'(addrs[3]), 32'h004);
    end

    // Reset mid-run after beat 3, with the buffer filled under backpressure
    run_xfer("midrst", 10, 12'h000, 0, 0, 3);
    check("midrst_beats_before", 32'(beats.size()), 32'd3);
    @(negedge clk);
    m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_stalled_valid", 32'(m_tvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("midrst");
    run_xfer("after_rst", 2, 12'h000, 0, 0, 0);
    fill_seq(2);
    check_stream("after_rst");
    check("after_rst_done_cyc", 32'(done_cyc), 32'(2 + FL + 3));

`ifdef XN_SRC_FLUSH_EN
    // Flush: 7,8,9 then ten zero beats, tlast on beat 13
    run_xfer("flush", 3, 12'h190, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(7); exp_q.push_back(8); exp_q.push_back(9);
    check_stream("flush");
    check("flush_nreads", 32'(addrs.size()), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
